// File: rtl/cal_pkg.sv
// Shared calendar types: sequencer states, BCD digit type and day-of-year limits.
package cal_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StSettle
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam int unsigned BCD_MAX_DIGIT   = 9;
    localparam int unsigned DEFAULT_MAX_DAY = 99;

    // True when a nibble is a legal decimal digit.
    function automatic logic bcd_digit_ok(bcd_t d);
        return d <= bcd_t'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/day_sequencer_if.sv
// Front-end / translator bundle around the day sequencer.
interface day_sequencer_if;
    import cal_pkg::*;

    logic run;
    logic advance;
    logic load;
    bcd_t load_tens;
    bcd_t load_ones;
    logic leap;

    bcd_t tens;
    bcd_t ones;
    logic leap_q;
    logic busy;
    logic out_valid;
    logic wrap;
    logic load_err;
    logic overrun;

    // Front end: drives controls, observes translator-side state.
    modport master (
        output run, advance, load, load_tens, load_ones, leap,
        input  tens, ones, leap_q, busy, out_valid, wrap, load_err, overrun
    );

    // Sequencer side.
    modport slave (
        input  run, advance, load, load_tens, load_ones, leap,
        output tens, ones, leap_q, busy, out_valid, wrap, load_err, overrun
    );

endinterface

// File: rtl/bcd2_inc.sv
// Two-digit BCD incrementer; MAX_DAY rolls over to 01 and raises wrap_o.
module bcd2_inc
    import cal_pkg::*;
#(
    parameter int unsigned MAX_DAY = DEFAULT_MAX_DAY
) (
    input  bcd_t tens_i,
    input  bcd_t ones_i,
    output bcd_t tens_o,
    output bcd_t ones_o,
    output logic wrap_o
);

    localparam bcd_t MaxTens = bcd_t'(MAX_DAY / 10);
    localparam bcd_t MaxOnes = bcd_t'(MAX_DAY % 10);

    // Successor of the current day, purely in BCD.
    always_comb begin
        tens_o = tens_i;
        ones_o = ones_i + 4'd1;
        wrap_o = 1'b0;
        if (tens_i == MaxTens && ones_i == MaxOnes) begin
            tens_o = 4'd0;
            ones_o = 4'd1;
            wrap_o = 1'b1;
        end else if (ones_i == bcd_t'(BCD_MAX_DIGIT)) begin
            ones_o = 4'd0;
            tens_o = tens_i + 4'd1;
        end
    end

endmodule

// File: rtl/day_sequencer.sv
// Owns the day-of-year fed to the month/day translator and tracks its settle latency.
module day_sequencer
    import cal_pkg::*;
#(
    parameter int unsigned MAX_DAY  = DEFAULT_MAX_DAY,
    parameter int unsigned XLAT_LAT = 2
) (
    input logic            clock,
    input logic            reset,
    day_sequencer_if.slave bus
);

    localparam int unsigned CntW = $clog2(XLAT_LAT + 1);
    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CntLoad = cnt_t'(XLAT_LAT);
    localparam cnt_t CntOne  = cnt_t'(1);
    localparam bcd_t MaxTens = bcd_t'(MAX_DAY / 10);
    localparam bcd_t MaxOnes = bcd_t'(MAX_DAY % 10);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    bcd_t   tens_q, tens_d, ones_q, ones_d;
    logic   pending_q, pending_d;
    logic   leap_held_q, leap_held_d;
    logic   load_err_q, load_err_d;
    logic   overrun_q, overrun_d;
    logic   wrap_q, wrap_d;
    logic   out_valid_q, out_valid_d;

    bcd_t   inc_tens, inc_ones;
    logic   inc_wrap;
    logic   adv, load_ok, blocked;

    bcd2_inc #(
        .MAX_DAY(MAX_DAY)
    ) u_inc (
        .tens_i(tens_q),
        .ones_i(ones_q),
        .tens_o(inc_tens),
        .ones_o(inc_ones),
        .wrap_o(inc_wrap)
    );

    assign adv     = bus.run & bus.advance;
    assign load_ok = bcd_digit_ok(bus.load_tens) && bcd_digit_ok(bus.load_ones) &&
                     !(bus.load_tens == 4'd0 && bus.load_ones == 4'd0) &&
                     ((bus.load_tens < MaxTens) ||
                      (bus.load_tens == MaxTens && bus.load_ones <= MaxOnes));

    // Next state: load beats leap change beats advance; a blocked tick is parked in pending.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pending_d   = pending_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        leap_held_d = leap_held_q;
        load_err_d  = load_err_q;
        overrun_d   = overrun_q;
        wrap_d      = 1'b0;
        out_valid_d = 1'b0;
        blocked     = 1'b0;

        if (bus.load && load_ok) begin
            tens_d     = bus.load_tens;
            ones_d     = bus.load_ones;
            load_err_d = 1'b0;
            pending_d  = 1'b0;
            state_d    = StSettle;
            cnt_d      = CntLoad;
            blocked    = adv;
        end else begin
            // A rejected load does not block the rest of the cycle.
            if (bus.load) begin
                load_err_d = 1'b1;
            end
            if (bus.leap != leap_held_q) begin
                leap_held_d = bus.leap;
                state_d     = StSettle;
                cnt_d       = CntLoad;
                blocked     = adv;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (adv) begin
                            tens_d  = inc_tens;
                            ones_d  = inc_ones;
                            wrap_d  = inc_wrap;
                            state_d = StSettle;
                            cnt_d   = CntLoad;
                        end
                    end
                    StSettle: begin
                        blocked = adv;
                        if (cnt_q == '0) begin
                            // Count of zero means out_valid is showing and a tick is parked.
                            if (pending_q) begin
                                tens_d    = inc_tens;
                                ones_d    = inc_ones;
                                wrap_d    = inc_wrap;
                                pending_d = 1'b0;
                                cnt_d     = CntLoad;
                            end else begin
                                state_d = StIdle;
                            end
                        end else if (cnt_q == CntOne) begin
                            out_valid_d = 1'b1;
                            cnt_d       = '0;
                            if (!pending_q) begin
                                state_d = StIdle;
                            end
                        end else begin
                            cnt_d = cnt_q - CntOne;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        if (blocked) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset; reset starts a settle of the 01 value.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StSettle;
            cnt_q       <= CntLoad;
            pending_q   <= 1'b0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd1;
            leap_held_q <= 1'b0;
            load_err_q  <= 1'b0;
            overrun_q   <= 1'b0;
            wrap_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            leap_held_q <= leap_held_d;
            load_err_q  <= load_err_d;
            overrun_q   <= overrun_d;
            wrap_q      <= wrap_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.tens      = tens_q;
    assign bus.ones      = ones_q;
    assign bus.leap_q    = leap_held_q;
    assign bus.busy      = (state_q == StSettle);
    assign bus.out_valid = out_valid_q;
    assign bus.wrap      = wrap_q;
    assign bus.load_err  = load_err_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_day_sequencer.sv
// Self-checking bench for day_sequencer: timeline model plus directed literal checks.
module tb_day_sequencer;
    import cal_pkg::*;

    localparam int LAT  = 2;
    localparam int MAXD = 99;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    day_sequencer_if bus ();

    day_sequencer #(
        .MAX_DAY (MAXD),
        .XLAT_LAT(LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: day as an integer, and the cycle in which out_valid is due.
    bit m_on   = 1'b0;
    int m_day  = 1;
    bit m_leap = 1'b0;
    bit m_err  = 1'b0;
    bit m_ovr  = 1'b0;
    bit m_pend = 1'b0;
    bit m_wrap = 1'b0;
    int m_valid_at = -1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_busy(input int c);
        return (c < m_valid_at) || (c == m_valid_at && m_pend);
    endfunction

    task automatic m_bump();
        if (m_day == MAXD) begin
            m_day  = 1;
            m_wrap = 1'b1;
        end else begin
            m_day = m_day + 1;
        end
    endtask

    // Advance the model by the inputs seen at the end of cycle cyc.
    task automatic model_step();
        bit adv, blocked, pend0, busy0, legal;
        int v;
        if (reset) begin
            m_on = 1'b1; m_day = 1; m_leap = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
            m_pend = 1'b0; m_wrap = 1'b0; m_valid_at = cyc + 1 + LAT;
        end else if (m_on) begin
            adv     = bus.run && bus.advance;
            blocked = 1'b0;
            pend0   = m_pend;
            busy0   = m_busy(cyc);
            m_wrap  = 1'b0;
            v       = int'(bus.load_tens) * 10 + int'(bus.load_ones);
            legal   = bus.load_tens <= 9 && bus.load_ones <= 9 && v >= 1 && v <= MAXD;
            if (bus.load && legal) begin
                m_day = v; m_err = 1'b0; m_pend = 1'b0;
                m_valid_at = cyc + 1 + LAT; blocked = adv;
            end else begin
                if (bus.load) m_err = 1'b1;
                if (bus.leap != m_leap) begin
                    m_leap = bus.leap; m_valid_at = cyc + 1 + LAT; blocked = adv;
                end else if (!busy0) begin
                    if (adv) begin
                        m_bump();
                        m_valid_at = cyc + 1 + LAT;
                    end
                end else begin
                    blocked = adv;
                    if (cyc == m_valid_at && m_pend) begin
                        m_bump();
                        m_pend = 1'b0;
                        m_valid_at = cyc + 1 + LAT;
                    end
                end
            end
            if (blocked) begin
                if (pend0) m_ovr = 1'b1;
                else m_pend = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
            cyc++;
        end
    end

    // Compare every output with the model just after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (m_on) begin
                check("tens", int'(bus.tens), m_day / 10);
                check("ones", int'(bus.ones), m_day % 10);
                check("leap_q", int'(bus.leap_q), int'(m_leap));
                check("busy", int'(bus.busy), int'(m_busy(cyc)));
                check("out_valid", int'(bus.out_valid), int'(cyc == m_valid_at));
                check("wrap", int'(bus.wrap), int'(m_wrap));
                check("load_err", int'(bus.load_err), int'(m_err));
                check("overrun", int'(bus.overrun), int'(m_ovr));
            end
        end
    end

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        bus.load = 1'b1; bus.load_tens = t; bus.load_ones = o;
        @(negedge clock);
        bus.load = 1'b0;
    endtask

    task automatic do_adv();
        bus.advance = 1'b1;
        @(negedge clock);
        bus.advance = 1'b0;
    endtask

    task automatic settle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("settle_bound", int'(n < 20), 1);
        @(negedge clock);
    endtask

    typedef struct packed {
        logic       adv;
        logic       ld;
        logic [3:0] lt;
        logic [3:0] lo;
        logic       lp;
    } vec_t;

    vec_t vecs [12] = '{
        '{1'b1, 1'b1, 4'd2, 4'd8,  1'b1},
        '{1'b1, 1'b0, 4'd0, 4'd0,  1'b1},
        '{1'b0, 1'b0, 4'd0, 4'd0,  1'b1},
        '{1'b0, 1'b0, 4'd0, 4'd0,  1'b1},
        '{1'b1, 1'b0, 4'd0, 4'd0,  1'b1},
        '{1'b0, 1'b0, 4'd0, 4'd0,  1'b1},
        '{1'b0, 1'b0, 4'd0, 4'd0,  1'b0},
        '{1'b0, 1'b1, 4'd9, 4'd9,  1'b0},
        '{1'b1, 1'b0, 4'd0, 4'd0,  1'b0},
        '{1'b0, 1'b0, 4'd0, 4'd0,  1'b0},
        '{1'b1, 1'b1, 4'd1, 4'hC,  1'b0},
        '{1'b0, 1'b0, 4'd0, 4'd0,  1'b0}
    };

    initial begin
        reset = 1'b1;
        bus.run = 1'b1; bus.advance = 1'b0; bus.load = 1'b0;
        bus.load_tens = 4'd0; bus.load_ones = 4'd0; bus.leap = 1'b0;
        repeat (2) @(negedge clock);

        // Reset release and first settle.
        reset = 1'b0;
        check("rst_tens", int'(bus.tens), 0);
        check("rst_ones", int'(bus.ones), 1);
        check("rst_busy", int'(bus.busy), 1);
        check("rst_ov", int'(bus.out_valid), 0);
        @(negedge clock);
        check("rst_busy2", int'(bus.busy), 1);
        @(negedge clock);
        check("rst_ov_pulse", int'(bus.out_valid), 1);
        check("rst_idle", int'(bus.busy), 0);
        @(negedge clock);
        check("rst_ov_end", int'(bus.out_valid), 0);

        // Load 3/1 then advance.
        do_load(4'd3, 4'd1);
        check("ld31_tens", int'(bus.tens), 3);
        check("ld31_busy", int'(bus.busy), 1);
        settle();
        do_adv();
        check("adv32_ones", int'(bus.ones), 2);
        check("adv32_busy", int'(bus.busy), 1);
        repeat (2) @(negedge clock);
        check("adv32_ov", int'(bus.out_valid), 1);
        @(negedge clock);

        // 99 rolls over to 01.
        do_load(4'd9, 4'd9);
        settle();
        do_adv();
        check("wrap_tens", int'(bus.tens), 0);
        check("wrap_ones", int'(bus.ones), 1);
        check("wrap_pulse", int'(bus.wrap), 1);
        @(negedge clock);
        check("wrap_end", int'(bus.wrap), 0);
        settle();

        // Load validation.
        do_load(4'hA, 4'd0);
        check("bad_err", int'(bus.load_err), 1);
        check("bad_tens", int'(bus.tens), 0);
        check("bad_busy", int'(bus.busy), 0);
        do_load(4'd0, 4'd0);
        check("zero_err", int'(bus.load_err), 1);
        do_load(4'd0, 4'd5);
        check("ok_err", int'(bus.load_err), 0);
        check("ok_ones", int'(bus.ones), 5);
        settle();

        // Three back-to-back ticks: one applied, one parked, one lost.
        do_load(4'd1, 4'd0);
        settle();
        bus.advance = 1'b1;
        @(negedge clock);
        check("burst_first", int'(bus.ones), 1);
        repeat (2) @(negedge clock);
        bus.advance = 1'b0;
        check("burst_ovr", int'(bus.overrun), 1);
        settle();
        check("burst_tens", int'(bus.tens), 1);
        check("burst_ones", int'(bus.ones), 2);

        // Leap toggle while idle.
        do_load(4'd6, 4'd0);
        settle();
        bus.leap = 1'b1;
        @(negedge clock);
        check("leap_follow", int'(bus.leap_q), 1);
        check("leap_busy1", int'(bus.busy), 1);
        @(negedge clock);
        check("leap_busy2", int'(bus.busy), 1);
        @(negedge clock);
        check("leap_ov", int'(bus.out_valid), 1);
        check("leap_idle", int'(bus.busy), 0);
        @(negedge clock);

        // Reset mid-settle suppresses the in-flight out_valid.
        do_adv();
        check("pre_rst_ones", int'(bus.ones), 1);
        reset = 1'b1;
        bus.leap = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("mid_rst_ones", int'(bus.ones), 1);
        check("mid_rst_tens", int'(bus.tens), 0);
        @(negedge clock);
        check("mid_rst_no_ov", int'(bus.out_valid), 0);
        check("mid_rst_ovr", int'(bus.overrun), 0);
        @(negedge clock);
        check("post_rst_ov", int'(bus.out_valid), 1);
        @(negedge clock);

        // run=0 ignores advance.
        bus.run = 1'b0;
        do_adv();
        check("norun_ones", int'(bus.ones), 1);
        check("norun_busy", int'(bus.busy), 0);
        bus.run = 1'b1;

        // Overlapping load / leap / advance vectors, checked by the model.
        foreach (vecs[i]) begin
            bus.advance = vecs[i].adv; bus.load = vecs[i].ld;
            bus.load_tens = vecs[i].lt; bus.load_ones = vecs[i].lo;
            bus.leap = vecs[i].lp;
            @(negedge clock);
        end
        bus.advance = 1'b0; bus.load = 1'b0;
        repeat (12) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/day_sequencer.md
# day_sequencer

Controller that owns the day-of-year value fed to the month/day translator. Holds a two-digit BCD day-of-year, advances it on a day tick, accepts validated loads and leap changes, and tracks the translator's pipeline latency so downstream logic knows when month/day outputs are current. Sits between the tick/button front end and the translator inputs.

## Interface
- `MAX_DAY`, default 99: last legal day-of-year; the successor of `MAX_DAY` is 01.
- `XLAT_LAT`, default 2: translator latency in cycles from a tens/ones change to a stable month/day.
- `clock` in 1: single system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; when 0, `advance` is ignored.
- `advance` in 1: one-cycle day tick.
- `load` in 1: one-cycle strobe; capture `load_tens`/`load_ones`.
- `load_tens` in 4: BCD tens digit for load.
- `load_ones` in 4: BCD ones digit for load.
- `leap` in 1: leap-year flag, forwarded to the translator.
- `tens` out 4: BCD tens digit driven to the translator.
- `ones` out 4: BCD ones digit driven to the translator.
- `leap_q` out 1: registered `leap` driven to the translator.
- `busy` out 1: translator output not yet consistent with `tens`/`ones`/`leap_q`.
- `out_valid` out 1: one-cycle pulse in the first cycle translator outputs are current.
- `wrap` out 1: one-cycle pulse coinciding with the `MAX_DAY`→01 update.
- `load_err` out 1: sticky; the last load was rejected.
- `overrun` out 1: sticky; an advance was lost.

## Operation
- States: IDLE (settled, waiting), SETTLE (counting down `XLAT_LAT`).
- Priority per cycle: `reset` > `load` > `leap` change > `advance`.
- Load is legal when both digits ≤ 9 and the value is 01..`MAX_DAY`.
  - Legal: update digits, clear `load_err`, clear pending, enter SETTLE.
  - Illegal: digits unchanged, set `load_err`, no state change.
- Leap change (`leap` ≠ `leap_q`): update `leap_q`, enter SETTLE and restart the counter.
- `advance` with `run`=1:
  - In IDLE: BCD increment, enter SETTLE. Ones 9→0 with tens+1; `MAX_DAY`→01 and pulse `wrap`.
  - In SETTLE: set `pending`. If `pending` is already set, set `overrun` and drop the tick.
  - Also when blocked by a same-cycle `load` or leap change: same pending/overrun rule.
- SETTLE: the counter loads `XLAT_LAT` and decrements each cycle. At zero, pulse `out_valid`. Then:
  - If `pending`, apply one increment, clear `pending`, stay in SETTLE.
  - Otherwise go to IDLE.
- `busy` = (state == SETTLE).
- `run`=0 does not clear `pending`.
- Digit arithmetic is BCD only; no binary conversion inside this block. The counter is `$clog2(XLAT_LAT+1)` bits wide.

## Timing
- Reset values: `tens`=0, `ones`=1, `leap_q`=0, `load_err`=0, `overrun`=0, `wrap`=0, `out_valid`=0, `pending`=0, state SETTLE, counter=`XLAT_LAT`, `busy`=1.
- After reset deasserts in cycle R, `out_valid` pulses in cycle R+`XLAT_LAT`.
- Advance accepted in cycle N: new digits visible in N+1; `busy` high N+1..N+`XLAT_LAT`; `out_valid` pulses in N+1+`XLAT_LAT`; `busy` low in that same cycle.
- Load and leap follow the same N+1 / N+1+`XLAT_LAT` timing.
- Pending advance: applied in the `out_valid` cycle; digits change the next cycle.
- `reset` in mid-SETTLE: discards `pending`, restores reset values, and suppresses any in-flight `out_valid`.
- `load` during SETTLE: restarts the counter; no `out_valid` for the superseded value.

## Structure
- Shared package `cal_pkg`: state enum (IDLE, SETTLE), BCD digit typedef, `BCD_MAX_DIGIT`=9, default `MAX_DAY`.
- Sub-module `bcd2_inc`, purely combinational: two-digit BCD incrementer with wrap-to-01 at `MAX_DAY`, plus a wrap flag output.
- Controller FSM, counter, pending logic and sticky flags live in `day_sequencer`.

## Test plan
- Reset, then idle with `run`=1: digits 0/1; `out_valid` 2 cycles after reset release; `busy` low afterwards.
- Load 3/1, then advance: digits become 3/2 the next cycle; `out_valid` 3 cycles after the advance.
- Load 9/9, then advance: digits 0/1 with `wrap`=1 in the same update cycle.
- Load digits A/0 (tens > 9): `load_err`=1, digits unchanged. Then load 0/0: `load_err` stays 1. Then load 0/5: `load_err`=0.
- Three `advance` pulses on consecutive cycles from 1/0: 1/1, then 1/2 after settle; `overrun`=1; final value 1/2.
- Toggle `leap` while IDLE at 6/0: `leap_q` follows the next cycle, `busy` for 2 cycles, one `out_valid`. Assert `reset` during SETTLE: no `out_valid` for the pre-reset value.
